// File: rtl/priority_encoder_7seg_scan.sv
// priority_encoder_7seg_scan
//   Registered priority encoder with a multiplexed hex 7-segment readout.
//   A request vector is captured on a strobe, the winning bit (highest or
//   lowest set bit, chosen per capture) is encoded on the following edge,
//   and the index is scanned across common-anode digits.
//
// Ports
//   clk        in   1       single clock, rising edge
//   rst        in   1       synchronous, active-high reset
//   in         in   WIDTH   request vector
//   sample     in   1       capture in / lsb_first on this edge
//   lsb_first  in   1       0 = highest set bit wins, 1 = lowest set bit wins
//   idx        out  IW      registered winning index
//   valid      out  1       captured vector had at least one bit set
//   changed    out  1       one-cycle pulse when {valid,idx} changes
//   seg        out  7       active-low segments {a,b,c,d,e,f,g}
//   an         out  DIGITS  active-low digit enables, an[0] = low nibble

module priority_encoder_7seg_scan #(
  parameter int WIDTH    = 16,
  parameter int DIGITS   = 2,
  parameter int SCAN_DIV = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in,
  input  logic                     sample,
  input  logic                     lsb_first,
  output logic [$clog2(WIDTH)-1:0] idx,
  output logic                     valid,
  output logic                     changed,
  output logic [6:0]               seg,
  output logic [DIGITS-1:0]        an
);

  localparam int IW = $clog2(WIDTH);
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int NW = 4 * DIGITS;

  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Returns {found, index}. Every set bit is visited; for MSB-first the last
  // hit (highest) is kept, for LSB-first only the first hit (lowest) is kept.
  function automatic logic [IW:0] encode(input logic [WIDTH-1:0] vec,
                                         input logic             lsb);
    logic [IW-1:0] pos;
    logic          found;
    pos   = '0;
    found = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i] && (!lsb || !found)) begin
        pos   = IW'(i);
        found = 1'b1;
      end else begin
        pos   = pos;
        found = found;
      end
    end
    return {found, pos};
  endfunction

  // Hex glyph, active-low abcdefg.
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'b0000001;
      4'h1:    g = 7'b1001111;
      4'h2:    g = 7'b0010010;
      4'h3:    g = 7'b0000110;
      4'h4:    g = 7'b1001100;
      4'h5:    g = 7'b0100100;
      4'h6:    g = 7'b0100000;
      4'h7:    g = 7'b0001111;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0000100;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b1100000;
      4'hC:    g = 7'b0110001;
      4'hD:    g = 7'b1000010;
      4'hE:    g = 7'b0110000;
      4'hF:    g = 7'b0111000;
      default: g = SEG_DASH;
    endcase
    return g;
  endfunction

  logic [WIDTH-1:0] in_r;
  logic             mode_r;
  logic [CW-1:0]    scan_cnt_r;
  logic [DW-1:0]    dig_ptr_r;

  logic [IW:0]      enc_s;
  logic [NW-1:0]    ext_s;
  logic [3:0]       nib_s;
  logic [6:0]       seg_s;
  logic [DIGITS-1:0] an_s;

  // Capture stage: request vector and priority mode, held while sample is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_r   <= '0;
      mode_r <= 1'b0;
    end else if (sample) begin
      in_r   <= in;
      mode_r <= lsb_first;
    end
  end

  // Encoder applied to the captured vector.
  always_comb begin
    enc_s = encode(in_r, mode_r);
  end

  // Encode stage: result register plus change detector against the previous result.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      valid   <= 1'b0;
      changed <= 1'b0;
    end else begin
      idx     <= enc_s[IW-1:0];
      valid   <= enc_s[IW];
      changed <= (enc_s != {valid, idx});
    end
  end

  // Scan timing: dwell counter and digit pointer, both wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_r <= '0;
      dig_ptr_r  <= '0;
    end else if (scan_cnt_r == CW'(SCAN_DIV - 1)) begin
      scan_cnt_r <= '0;
      dig_ptr_r  <= (dig_ptr_r == DW'(DIGITS - 1)) ? '0 : dig_ptr_r + DW'(1);
    end else begin
      scan_cnt_r <= scan_cnt_r + CW'(1);
    end
  end

  // Readout decode: pick the nibble for the current digit and its glyph.
  always_comb begin
    ext_s = NW'(idx);
    nib_s = 4'h0;
    for (int d = 0; d < DIGITS; d++) begin
      if (dig_ptr_r == DW'(d)) begin
        nib_s = ext_s[4*d +: 4];
      end else begin
        nib_s = nib_s;
      end
    end
    if (valid) begin
      seg_s = glyph(nib_s);
    end else begin
      seg_s = SEG_DASH;
    end
    an_s = ~(DIGITS'(1) << dig_ptr_r);
  end

  // Readout registers: digit enable and segment data switch on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= SEG_BLANK;
      an  <= '1;
    end else begin
      seg <= seg_s;
      an  <= an_s;
    end
  end

endmodule
